// File: rtl/ram_loader.sv
// Boot-time loader: parses framed UART bytes (A5, addr_hi, addr_lo, len, data..., csum)
// and drives the data RAM write port, stalling the CPU via busy while a frame is open.
module ram_loader #(
  parameter int addr_width     = 11,
  parameter int data_width     = 8,
  parameter int timeout_cycles = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [addr_width-1:0] w_addr,
  output logic [data_width-1:0] din,
  output logic                  w_en,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR_HI = 3'd1,
    S_ADDR_LO = 3'd2,
    S_LEN     = 3'd3,
    S_DATA    = 3'd4,
    S_CSUM    = 3'd5
  } state_t;

  localparam int            tw     = $clog2(timeout_cycles + 1);
  localparam logic [tw-1:0] t_last = tw'(timeout_cycles - 1);

  // Handshake: rx_valid is a one-cycle strobe with no backpressure; every
  // strobed byte is consumed in the cycle it is presented.
  state_t                state;
  logic [7:0]            acc;
  logic [7:0]            hi_q;
  logic [8:0]            rem;
  logic [addr_width-1:0] addr_ptr;
  logic [tw-1:0]         tcnt;

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      acc      <= '0;
      hi_q     <= '0;
      rem      <= '0;
      addr_ptr <= '0;
      tcnt     <= '0;
      w_addr   <= '0;
      din      <= '0;
      w_en     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      w_en <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
      if (state != S_IDLE && !rx_valid) begin
        // Idle gap inside a frame: abort once the allowed gap is used up.
        if (tcnt == t_last) begin
          state <= S_IDLE;
          busy  <= 1'b0;
          err   <= 1'b1;
          tcnt  <= '0;
        end else begin
          tcnt <= tcnt + tw'(1);
        end
      end else if (rx_valid) begin
        tcnt <= '0;
        case (state)
          S_IDLE: begin
            if (rx_data == 8'hA5) begin
              state <= S_ADDR_HI;
              busy  <= 1'b1;
              acc   <= '0;
            end
          end
          S_ADDR_HI: begin
            hi_q  <= rx_data;
            acc   <= acc + rx_data;
            state <= S_ADDR_LO;
          end
          S_ADDR_LO: begin
            addr_ptr <= addr_width'({hi_q, rx_data});
            acc      <= acc + rx_data;
            state    <= S_LEN;
          end
          S_LEN: begin
            rem   <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
            acc   <= acc + rx_data;
            state <= S_DATA;
          end
          S_DATA: begin
            w_en     <= 1'b1;
            w_addr   <= addr_ptr;
            din      <= data_width'(rx_data);
            addr_ptr <= addr_ptr + addr_width'(1);
            acc      <= acc + rx_data;
            rem      <= rem - 9'd1;
            if (rem == 9'd1) state <= S_CSUM;
          end
          S_CSUM: begin
            state <= S_IDLE;
            busy  <= 1'b0;
            if (rx_data == acc) done <= 1'b1;
            else                err  <= 1'b1;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// Randomized bench for ram_loader: a frame-level model predicts every RAM write
// and the done/err outcome; a negedge monitor scoreboards the write port.
module tb_ram_loader;

  localparam int aw  = 11;
  localparam int tmo = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic [aw-1:0] w_addr;
  logic [7:0]    din;
  logic          w_en, busy, done, err;
  logic [2:0]    dbg_state;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  logic [aw+7:0] exp_q[$];
  logic [7:0]    payload[$];

  ram_loader #(.addr_width(aw), .data_width(8), .timeout_cycles(tmo)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .w_addr(w_addr), .din(din), .w_en(w_en), .busy(busy),
    .done(done), .err(err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (w_en) begin
      if (exp_q.size() > 0) check("wr_addr_data", {13'd0, w_addr, din}, {13'd0, exp_q.pop_front()});
      else                  check("wr_unexpected", w_en, 0);
    end
    if (done || err) check("done_err_excl", done & err, 0);
    if (done) done_cnt++;
    if (err)  err_cnt++;
  end

  // drivers (called at a negedge; return at the negedge after the byte's edge)
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_w_en"}, w_en, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_w_addr"}, w_addr, 0);
    check({tag, "_din"}, din, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  task automatic send_frame(input logic [7:0] hi, input logic [7:0] lo, input bit corrupt,
                            input int gmax);
    int n, start, d0, e0;
    logic [7:0] len, sum, cs;
    n     = payload.size();
    len   = 8'(n);
    sum   = 8'(hi + lo + len);
    foreach (payload[i]) sum = 8'(sum + payload[i]);
    start = int'({hi, lo}) % (1 << aw);
    d0    = done_cnt;
    e0    = err_cnt;
    send_byte(8'hA5);
    check("busy_rise", busy, 1);
    idle($urandom_range(0, gmax));
    send_byte(hi);  idle($urandom_range(0, gmax));
    send_byte(lo);  idle($urandom_range(0, gmax));
    send_byte(len); idle($urandom_range(0, gmax));
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({aw'((start + i) % (1 << aw)), payload[i]});
      send_byte(payload[i]);
      check("wen_latency", w_en, 1);
      check("busy_data", busy, 1);
      idle($urandom_range(0, gmax));
    end
    cs = corrupt ? (sum ^ 8'($urandom_range(1, 255))) : sum;
    send_byte(cs);
    check("done_pulse", done, !corrupt);
    check("err_pulse", err, corrupt);
    check("busy_fall", busy, 0);
    @(negedge clk);
    check("done_cnt", done_cnt - d0, !corrupt);
    check("err_cnt", err_cnt - e0, corrupt);
    check("exp_q_empty", exp_q.size(), 0);
  endtask

  initial begin
    int d0, e0;
    logic [7:0] noise[3];
    idle(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    idle(2);

    // good frame and its bad-checksum twin
    payload = '{8'h11, 8'h22, 8'h33};
    send_frame(8'h00, 8'h10, 1'b0, 0);
    send_frame(8'h00, 8'h10, 1'b1, 2);

    // 256-byte frame that wraps the address space
    payload.delete();
    for (int i = 0; i < 256; i++) payload.push_back(8'(i));
    send_frame(8'h07, 8'hFE, 1'b0, 1);

    // noise in IDLE
    noise = '{8'h00, 8'hFF, 8'h5A};
    foreach (noise[i]) begin
      send_byte(noise[i]);
      check("noise_busy", busy, 0);
      check("noise_wen", w_en, 0);
    end

    // embedded header byte as data, upper address bits set
    payload = '{8'hA5, 8'h01, 8'hA5};
    send_frame(8'hF9, 8'h33, 1'b0, 0);

    // timeout after a partial header
    e0 = err_cnt;
    send_byte(8'hA5);
    send_byte(8'h00);
    idle(tmo - 1);
    check("tmo_err_early", err, 0);
    check("tmo_busy_hold", busy, 1);
    idle(1);
    check("tmo_err", err, 1);
    check("tmo_busy_drop", busy, 0);
    idle(1);
    check("tmo_err_single", err_cnt - e0, 1);
    payload = '{8'h5C, 8'h00};
    send_frame(8'h02, 8'h00, 1'b0, 0);

    // reset after the second data byte
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h20);
    send_byte(8'h05);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({aw'(11'h120 + i), 8'(8'h40 + i)});
      send_byte(8'(8'h40 + i));
    end
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    idle(1);
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_no_err", err_cnt - e0, 0);
    check("midrst_writes", exp_q.size(), 0);
    payload = '{8'h99};
    send_frame(8'h03, 8'h21, 1'b0, 1);

    // random frames
    repeat (12) begin
      payload.delete();
      repeat ($urandom_range(1, 24))
        payload.push_back(($urandom_range(0, 5) == 0) ? 8'hA5 : 8'($urandom));
      send_frame(8'($urandom), 8'($urandom), 1'($urandom_range(0, 3) == 0), 3);
      idle($urandom_range(0, 4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_loader.md
# ram_loader

Boot-time loader that sits directly upstream of the data RAM write port. It accepts a framed byte stream from the UART receiver and writes the payload into data RAM at a host-supplied address. It holds the CPU off the RAM while a frame is in progress and reports completion or failure with single-cycle pulses.

## Interface
- `addr_width`, default 11: RAM address width. Matches the data RAM.
- `data_width`, default 8: RAM word width. Fixed at 8; the byte protocol assumes it.
- `timeout_cycles`, default 50000: idle cycles allowed between bytes inside a frame before the frame is aborted.
- `clk` input 1: the single clock, rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `rx_data` input 8: received byte; valid only while `rx_valid` is high.
- `rx_valid` input 1: one-cycle strobe per received byte.
- `w_addr` output addr_width: RAM write address.
- `din` output data_width: RAM write data.
- `w_en` output 1: RAM write enable, one cycle per payload byte.
- `busy` output 1: frame in progress. The CPU memory path uses it as a stall.
- `done` output 1: one-cycle pulse when a frame completes with a good checksum.
- `err` output 1: one-cycle pulse on checksum mismatch or timeout.

## Operation
- Frame format: `0xA5`, addr_hi, addr_lo, len, then len data bytes, then csum.
  - len = 0 means 256 data bytes.
  - Start address = {addr_hi, addr_lo}[addr_width-1:0]. Upper bits are ignored.
- States and transitions (each advances on one `rx_valid` byte unless stated):
  - IDLE: only `0xA5` moves to ADDR_HI. Any other byte is discarded silently.
  - ADDR_HI → ADDR_LO → LEN.
  - LEN → DATA.
  - DATA stays in DATA until the len-th byte, then moves to CSUM.
  - CSUM → IDLE.
- Checksum accumulator:
  - 8-bit, cleared on header acceptance.
  - Adds addr_hi, addr_lo, len and every data byte, modulo 256.
  - In CSUM, the received byte must equal the accumulator. Equal gives a `done` pulse; otherwise an `err` pulse.
- Writes are committed as data arrives and are never rolled back. A failed checksum leaves the data already written in RAM.
- Write address starts at the frame address and increments by 1 per data byte. It wraps from 2^addr_width−1 to 0.
- Remaining-byte counter is 9 bits: loaded with len (0 loads 256) and decremented on each data byte.
- Timeout:
  - Counter clears on every `rx_valid` and increments every cycle in non-IDLE states.
  - On reaching `timeout_cycles`, the FSM goes to IDLE and pulses `err`; there is no `done` pulse.
- `0xA5` received inside a frame is treated as ordinary data. There is no resynchronisation except by timeout or reset.
- Reset mid-frame returns to IDLE immediately. Partial writes remain in RAM, and no `done`/`err` pulse is issued.

## Timing
- Reset values:
  - `w_en`=0, `busy`=0, `done`=0, `err`=0.
  - `w_addr`=0, `din`=0.
  - FSM in IDLE; accumulator, counters and timeout counter all 0.
- All outputs are registered.
- Data byte with `rx_valid` in cycle N gives `w_en`=1 with `w_addr`/`din` valid in cycle N+1. The RAM captures it at the end of N+1.
- `busy` rises in cycle N+1 after the header byte is accepted in cycle N.
- Checksum byte in cycle N:
  - `done` or `err` is high in cycle N+1.
  - `busy` falls in the same cycle N+1.
- Timeout detected in cycle N gives `err` high and `busy` low in cycle N+1.
- Back-to-back `rx_valid` on consecutive cycles is supported at one byte per cycle with no loss.
- `w_en` is never high outside DATA-byte cycles. `done` and `err` are never high together.

## Test plan
- Good frame: A5 00 10 03 11 22 33 csum=0x79.
  - Writes 0x11@0x010, 0x22@0x011, 0x33@0x012 on three `w_en` cycles.
  - `done` pulses once; `busy` covers the frame.
- Bad checksum: same frame with csum=0x78.
  - All three writes still occur.
  - `err` pulses; no `done`.
- Wrap and 256 length: A5 07 FE 00, then 256 bytes of value i.
  - Writes go to 0x7FE, 0x7FF, 0x000…0x0FD.
  - Upper address bits ignored; `done` pulses on the correct checksum.
- Noise and embedded header:
  - Bytes 00 FF 5A in IDLE produce no `busy`.
  - A frame with data byte 0xA5 writes 0xA5 and completes normally.
- Timeout: with `timeout_cycles`=16, send A5 00 and then go silent.
  - `err` pulses in the cycle after 16 idle cycles; `busy` drops.
  - A following good frame completes.
- Reset mid-frame: assert `rst` after the second data byte.
  - Next cycle all outputs are at reset values; no pulse.
  - A new frame is accepted normally.
